// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin N_REQ:1 byte arbiter feeding a 16x-tick paced
//               UART transmit frame sequencer (start, DBIT data, stop).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_tick,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DBIT-1:0]      req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int c_GW = $clog2(N_REQ);
  localparam int c_NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            r_state;
  logic [4:0]        r_s;
  logic [c_NW-1:0]   r_n;
  logic [DBIT-1:0]   r_shreg;
  logic [c_GW-1:0]   r_ptr;

  logic              w_found;
  logic [c_GW-1:0]   w_win;
  logic [c_GW-1:0]   w_ptr_next;

  // Scan downward so the requester closest to r_ptr is the last to assign.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_win   = c_GW'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_ptr_next = (w_win == c_GW'(N_REQ - 1)) ? '0 : w_win + c_GW'(1);

  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && !reset && w_found) begin
      req_ready[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_n      <= '0;
      r_shreg  <= '0;
      r_ptr    <= '0;
      grant_id <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_shreg  <= req_data[int'(w_win)*DBIT +: DBIT];
            grant_id <= w_win;
            r_ptr    <= w_ptr_next;
            r_s      <= '0;
            r_n      <= '0;
            r_state  <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == 5'd15) begin
              r_s     <= '0;
              r_state <= DATA;
              tx      <= r_shreg[0];
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == 5'd15) begin
              r_s     <= '0;
              r_shreg <= r_shreg >> 1;
              if (r_n == c_NW'(DBIT - 1)) begin
                r_state <= STOP;
                tx      <= 1'b1;
              end else begin
                r_n <= r_n + c_NW'(1);
                tx  <= r_shreg[1];
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (r_s == 5'(SB_TICK - 1)) begin
              r_s     <= '0;
              r_state <= IDLE;
              tx      <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Bench for uart_tx_arbiter against a tick-indexed frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int FRAME   = (1 + DBIT) * 16 + SB_TICK;
  localparam int GW      = $clog2(N_REQ);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  s_tick = 1'b0;
  logic [N_REQ-1:0]      req_valid = '0;
  logic [N_REQ*DBIT-1:0] req_data = '0;
  logic [N_REQ-1:0]      req_ready;
  logic                  tx;
  logic                  busy;
  logic [GW-1:0]         grant_id;

  uart_tx_arbiter #(.N_REQ(N_REQ), .DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Model: a frame is just a tick index into start/data/stop.
  bit              m_active = 1'b0;
  int              m_t = 0;
  int              m_gid = 0;
  int              m_ptr = 0;
  logic [DBIT-1:0] m_byte = '0;
  bit              chk_en = 1'b0;

  int              g_acc;
  logic            g_tx, g_busy;
  logic [N_REQ-1:0] g_rdy;
  int              g_gid;
  int              g_rdy0_cnt = 0;
  logic [9:0]      g_bits;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got timeout expected completion at %0t", name, $time);
  endtask

  function automatic int winner(input logic [N_REQ-1:0] v, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  task automatic step(input logic r, input logic t, input logic [N_REQ-1:0] v,
                      input logic [N_REQ*DBIT-1:0] d);
    int w, exp_tx, exp_rdy;
    @(negedge clk);
    reset = r; s_tick = t; req_valid = v; req_data = d;
    #1;
    g_tx = tx; g_busy = busy; g_rdy = req_ready; g_gid = int'(grant_id);
    g_acc = -1;
    for (int i = 0; i < N_REQ; i++)
      if (req_ready[i] && v[i] && !r) g_acc = i;
    if (req_ready[0]) g_rdy0_cnt++;
    w = winner(v, m_ptr);
    if (!m_active)                  exp_tx = 1;
    else if (m_t < 16)              exp_tx = 0;
    else if (m_t < 16 + 16 * DBIT)  exp_tx = int'(m_byte[(m_t - 16) / 16]);
    else                            exp_tx = 1;
    exp_rdy = (r || m_active || w < 0) ? 0 : (1 << w);
    if (chk_en) begin
      check("tx", int'(tx), exp_tx);
      check("busy", int'(busy), int'(m_active));
      check("grant_id", int'(grant_id), m_gid);
      check("req_ready", int'(req_ready), exp_rdy);
    end
    if (r) begin
      m_active = 1'b0; m_t = 0; m_gid = 0; m_ptr = 0;
    end else if (!m_active) begin
      if (w >= 0) begin
        m_active = 1'b1; m_t = 0; m_byte = d[w*DBIT +: DBIT];
        m_gid = w; m_ptr = (w + 1) % N_REQ;
      end
    end else if (t) begin
      m_t++;
      if (m_t == FRAME) m_active = 1'b0;
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, '0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, '0, '0);
  endtask

  task automatic wait_accept(input logic [N_REQ-1:0] v, input logic [N_REQ*DBIT-1:0] d,
                             output int idx);
    idx = -1;
    for (int n = 0; n < 3000; n++) begin
      step(1'b0, 1'b1, v, d);
      if (g_acc >= 0) begin
        idx = g_acc;
        return;
      end
    end
    timeout("wait_accept");
  endtask

  // Runs ticks every clk until busy drops; the final step may accept the next byte.
  task automatic finish_frame(input logic [N_REQ-1:0] v, input logic [N_REQ*DBIT-1:0] d,
                              output int ticks);
    int n;
    ticks = 0; g_bits = '0;
    for (n = 0; n < 5000; n++) begin
      step(1'b0, 1'b1, v, d);
      if (!g_busy) break;
      if (ticks % 16 == 8 && ticks / 16 < 10) g_bits[ticks / 16] = g_tx;
      ticks++;
    end
    if (n == 5000) timeout("finish_frame");
  endtask

  initial begin
    int idx, ticks;
    int order[6];
    logic [N_REQ-1:0] v;
    logic [N_REQ*DBIT-1:0] d;

    // Reset state
    do_reset();
    check("reset_tx", int'(g_tx), 1);
    check("reset_busy", int'(g_busy), 0);
    check("reset_gid", g_gid, 0);

    // Single byte 0x55 from requester 0
    g_rdy0_cnt = 0;
    d = '0; d[7:0] = 8'h55;
    wait_accept(4'b0001, d, idx);
    check("single_idx", idx, 0);
    finish_frame(4'b0000, d, ticks);
    check("single_ticks", ticks, 160);
    check("single_bits", int'(g_bits), 10'h2AA);
    check("single_ready_clks", g_rdy0_cnt, 1);

    // Contention: all four valid from reset, each holding one byte
    do_reset();
    d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    v = 4'b1111;
    wait_accept(v, d, idx);
    for (int k = 0; k < 4; k++) begin
      order[k] = idx;
      if (idx >= 0) v[idx] = 1'b0;
      finish_frame(v, d, ticks);
      idx = g_acc;
    end
    for (int k = 0; k < 4; k++) check("contention_order", order[k], k);

    // Fairness: requesters 0 and 2 always valid
    do_reset();
    d = $urandom;
    wait_accept(4'b0101, d, idx);
    for (int k = 0; k < 6; k++) begin
      order[k] = idx;
      finish_frame(k == 5 ? 4'b0000 : 4'b0101, d, ticks);
      idx = g_acc;
    end
    for (int k = 0; k < 6; k++) check("fair_order", order[k], (k % 2) * 2);

    // Wrap: serve 2, then only 1 valid, then 1 and 2 valid
    do_reset();
    d = $urandom;
    wait_accept(4'b0100, d, idx);
    check("wrap_first", idx, 2);
    finish_frame(4'b0010, d, ticks);
    check("wrap_search", g_acc, 1);
    finish_frame(4'b0110, d, ticks);
    check("wrap_ptr", g_acc, 2);
    finish_frame(4'b0000, d, ticks);

    // Reset during data bit 4 of a 0x00 frame from requester 2
    do_reset();
    d = {8'hC3, 8'h00, 8'h11, 8'h22};
    wait_accept(4'b0100, d, idx);
    check("rstmid_idx", idx, 2);
    for (int k = 0; k < 88; k++) step(1'b0, 1'b1, 4'b0000, d);
    step(1'b1, 1'b1, 4'b1000, d);
    check("rstmid_ready_in_reset", int'(g_rdy), 0);
    step(1'b0, 1'b0, 4'b1000, d);
    check("rstmid_tx", int'(g_tx), 1);
    check("rstmid_busy", int'(g_busy), 0);
    check("rstmid_gid", g_gid, 0);
    check("rstmid_accept3", g_acc, 3);
    finish_frame(4'b0000, d, ticks);
    check("rstmid_ticks", ticks, 160);

    // Tick gating during START
    do_reset();
    d = '0; d[7:0] = 8'h96;
    wait_accept(4'b0001, d, idx);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'b0000, d);
    for (int k = 0; k < 1000; k++) step(1'b0, 1'b0, 4'b0000, d);
    check("gate_tx", int'(g_tx), 0);
    check("gate_busy", int'(g_busy), 1);
    finish_frame(4'b0000, d, ticks);
    check("gate_ticks", ticks, 155);

    // Randomized traffic against the model
    for (int k = 0; k < 20000; k++) begin
      logic r, t;
      r = ($urandom_range(0, 4999) == 0);
      t = ($urandom_range(0, 1) == 0);
      v = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) d[i*DBIT +: DBIT] = DBIT'($urandom);
      step(r, t, v, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmit line among N_REQ byte-stream requesters. Each requester gets round-robin access, one byte per grant. The block contains the frame-sequencing FSM (start, data, stop) and is paced by the 16x-oversampled baud tick from the baud tick generator (`s_tick`). It sits between on-chip message sources (status reporter, debug console, echo path, etc.) and the Basys3 `RsTx` pin.

## Interface
- `N_REQ`, 4: number of requesters; the implementation is checked for 2..8.
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: stop-bit length in ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `s_tick` input 1: one-clk-wide pulse, 16 per bit period, from the baud tick generator.
- `req_valid` input N_REQ: requester i holds a byte.
- `req_data` input N_REQ*DBIT: byte of requester i in bits [i*DBIT +: DBIT].
- `req_ready` output N_REQ: one-hot accept; a byte transfers when `req_valid[i] & req_ready[i]` at a rising edge.
- `tx` output 1: serial line, idle high.
- `busy` output 1: high whenever state is not IDLE.
- `grant_id` output clog2(N_REQ): index of the requester whose byte is being sent or was last sent.

## Operation
- States and transitions:
  - IDLE goes to START when a byte is accepted.
  - START goes to DATA after 16 ticks.
  - DATA goes to STOP after DBIT×16 ticks.
  - STOP goes to IDLE after SB_TICK ticks.
- Arbitration is combinational, in IDLE only. The winner is the first i with `req_valid[i]`, searching from `ptr` upward modulo N_REQ.
  - `req_ready` equals the one-hot winner while in IDLE, and is all-zero in any other state.
  - `req_ready` never has more than one bit set.
- On the accept edge:
  - latch the winner's `req_data` into the shift register;
  - load the winner's index into `grant_id`;
  - set `ptr` to winner+1 modulo N_REQ (wraps from N_REQ-1 to 0);
  - clear the tick counter `s` and the bit counter `n`;
  - move to START.
- Counters:
  - `s` is a 4-bit tick counter in START and DATA. It is 5 bits in STOP, counting 0..SB_TICK-1.
  - `s` advances only on `s_tick`.
  - When `s` reaches 15 on a tick (SB_TICK-1 in STOP), `s` returns to 0 and the bit or state advances.
- Data is sent LSB first. In DATA, at each bit end the shift register shifts right and `n` increments. The last bit ends when `n == DBIT-1`.
- `tx` is a register:
  - 1 in IDLE and STOP;
  - 0 in START;
  - shift register bit 0 in DATA.
- `s_tick` pulses arriving while in IDLE are ignored.
- The next frame may start on the clk immediately after STOP ends. There are no idle bits between frames.
- A requester dropping `req_valid` before it is accepted is legal. It simply loses arbitration for that cycle.
- `req_data` is sampled only on the accept edge. Changes at any other time have no effect.

## Timing
- Reset values:
  - state IDLE, `tx`=1, `busy`=0, `grant_id`=0, `ptr`=0;
  - `s`, `n` and the shift register are 0;
  - `req_ready` follows the arbitration rule with `ptr`=0.
- Accept to `tx` falling: 1 clk. `busy` rises in the same cycle `tx` falls.
- Frame length: (1+DBIT)×16 + SB_TICK ticks after the START state is entered, which is 160 ticks at the defaults.
- Reset asserted mid-frame:
  - next edge: `tx`=1, state IDLE, `ptr`=0;
  - the byte in flight is discarded and not re-sent;
  - no `req_ready` is asserted while `reset` is high.
- `reset` and `s_tick` in the same cycle: reset wins.
- Throughput: back-to-back frames with no gap at the tick level. There is a 1-clk IDLE bubble per frame.

## Test plan
- Single byte: `req_valid[0]`=1 with 0x55 for one accept cycle.
  - Expect `req_ready[0]` high for exactly one clk.
  - Expect `tx` = 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each bit exactly 16 ticks.
  - Expect `busy` low one clk after STOP ends. Total is 160 ticks.
- Contention: all four requesters valid (0xA0..0xA3) from reset.
  - Expect accept order 0,1,2,3, with `grant_id` matching and the frames back-to-back on `tx`.
- Fairness: requesters 0 and 2 continuously valid for 6 frames.
  - Expect grant order 0,2,0,2,0,2; requester 0 is never granted twice in a row.
- Wrap: `ptr`=3 after serving requester 2, then only requester 1 is valid.
  - Expect requester 1 to be granted (search wraps 3→0→1) and `ptr` to become 2.
- Reset mid-frame: assert `reset` during data bit 4 of a 0x00 frame.
  - Expect `tx`=1 and `busy`=0 on the next edge, and `grant_id`=0.
  - After release with requester 3 valid, expect a full clean frame for requester 3.
- Tick gating: hold `s_tick` low for 1000 clk during START.
  - Expect `tx` to stay 0 and state and counters to freeze.
  - Expect the frame to resume exactly when ticks return.
